// File: rtl/morph_pkg.sv
// Shared types and constants for the morphology pass sequencer.
// The filter latency and the counter sizing live here so every file agrees on them.
package morph_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPrime,
    StStream,
    StNext,
    StDone
  } state_e;

  localparam logic OP_ERODE  = 1'b0;
  localparam logic OP_DILATE = 1'b1;

  // Filter centre delay is width+1; the filter output register adds one more cycle.
  function automatic int unsigned morph_lag(input int unsigned width);
    return width + 32'd2;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  // prog_len of 0 runs one pass; values above 4 are clamped to 4.
  function automatic logic [1:0] last_pass_idx(input logic [2:0] len);
    if (len == 3'd0) begin
      return 2'd0;
    end else if (len >= 3'd4) begin
      return 2'd3;
    end
    return 2'(len - 3'd1);
  endfunction

endpackage

// File: rtl/morph_pass_sequencer_if.sv
// Frame-bank and filter bus between the sequencer (master) and the memories/filter (slave).
interface morph_pass_sequencer_if #(
  parameter int unsigned AW = 16
) ();

  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          rd_data;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          wr_data;
  logic          filt_reset;
  logic          filt_which;
  logic          filt_income;
  logic          filt_outcome;

  modport master (
    output rd_bank,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_bank,
    output wr_addr,
    output wr_data,
    output filt_reset,
    output filt_which,
    output filt_income,
    input  filt_outcome
  );

  modport slave (
    input  rd_bank,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_bank,
    input  wr_addr,
    input  wr_data,
    input  filt_reset,
    input  filt_which,
    input  filt_income,
    output filt_outcome
  );

endinterface

// File: rtl/morph_raster_cnt.sv
// Row/column wrap counter over a Width x Height raster, with last-pixel and border flags.
module morph_raster_cnt
  import morph_pkg::*;
#(
  parameter int unsigned Width  = 256,
  parameter int unsigned Height = 256,
  localparam int unsigned CW    = cnt_width(Width),
  localparam int unsigned RW    = cnt_width(Height)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          advance_i,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_o,
  output logic          border_o
);

  localparam logic [CW-1:0] ColLast = CW'(Width - 1);
  localparam logic [RW-1:0] RowLast = RW'(Height - 1);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (advance_i) begin
      if (col_q == ColLast) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o    = row_q;
  assign col_o    = col_q;
  assign last_o   = (row_q == RowLast) && (col_q == ColLast);
  assign border_o = (row_q == '0) || (row_q == RowLast) || (col_q == '0) || (col_q == ColLast);

endmodule

// File: rtl/morph_pass_sequencer.sv
// Runs up to four erode/dilate passes over a frame, ping-ponging between two 1-bit frame banks
// and streaming each frame through the external bit-serial 3x3 filter.
module morph_pass_sequencer
  import morph_pkg::*;
#(
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned HEIGHT = 256,
  parameter int unsigned AW     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] prog_ops,
  input  logic [2:0] prog_len,
  input  logic       prog_bank,
  input  logic       pad,
  input  logic       clear_border,
  output logic       busy,
  output logic       done,
  output logic       result_bank,
  morph_pass_sequencer_if.master bus
);

  localparam int unsigned N   = WIDTH * HEIGHT;
  localparam int unsigned LAG = morph_lag(WIDTH);
  localparam int unsigned FW  = $clog2(N + LAG);
  localparam int unsigned CW  = cnt_width(WIDTH);
  localparam int unsigned RW  = cnt_width(HEIGHT);

  localparam logic [FW-1:0] NumPix = FW'(N);
  localparam logic [FW-1:0] LagF   = FW'(LAG);

  state_e        state_q, state_d;
  logic [3:0]    ops_q, ops_d;
  logic [1:0]    last_pass_q, last_pass_d;
  logic [1:0]    pass_q, pass_d;
  logic          pad_q, pad_d;
  logic          cb_q, cb_d;
  logic          src_q, src_d;
  logic          result_q, result_d;
  logic [FW-1:0] f_q, f_d;

  logic          cur_op;
  logic [FW-1:0] feed_next;
  logic          cnt_clear, cnt_adv;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          raster_last, raster_border;

  assign cur_op    = ops_q[pass_q];
  assign feed_next = f_q + 1'b1;

  morph_raster_cnt #(
    .Width  (WIDTH),
    .Height (HEIGHT)
  ) u_raster (
    .clock     (clock),
    .reset     (reset),
    .clear_i   (cnt_clear),
    .advance_i (cnt_adv),
    .row_o     (row),
    .col_o     (col),
    .last_o    (raster_last),
    .border_o  (raster_border)
  );

  always_comb begin
    state_d         = state_q;
    ops_d           = ops_q;
    last_pass_d     = last_pass_q;
    pass_d          = pass_q;
    pad_d           = pad_q;
    cb_d            = cb_q;
    src_d           = src_q;
    result_d        = result_q;
    f_d             = f_q;
    busy            = 1'b0;
    done            = 1'b0;
    cnt_clear       = 1'b0;
    cnt_adv         = 1'b0;
    bus.rd_bank     = 1'b0;
    bus.rd_addr     = '0;
    bus.wr_en       = 1'b0;
    bus.wr_bank     = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = 1'b0;
    bus.filt_reset  = 1'b0;
    bus.filt_which  = 1'b0;
    bus.filt_income = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          ops_d       = prog_ops;
          last_pass_d = last_pass_idx(prog_len);
          pad_d       = pad;
          cb_d        = clear_border;
          src_d       = prog_bank;
          pass_d      = 2'd0;
          state_d     = StClear;
        end
      end
      StClear: begin
        busy           = 1'b1;
        bus.filt_reset = 1'b1;
        bus.filt_which = cur_op;
        state_d        = StPrime;
      end
      StPrime: begin
        // The filter shifts on every clock, so feed the pad value while the first read is in flight.
        busy            = 1'b1;
        bus.filt_which  = cur_op;
        bus.filt_income = pad_q;
        bus.rd_bank     = src_q;
        f_d             = '0;
        cnt_clear       = 1'b1;
        state_d         = StStream;
      end
      StStream: begin
        busy            = 1'b1;
        bus.filt_which  = cur_op;
        bus.rd_bank     = src_q;
        bus.filt_income = (f_q < NumPix) ? bus.rd_data : pad_q;
        f_d             = feed_next;
        if (feed_next < NumPix) begin
          bus.rd_addr = AW'(feed_next);
        end
        if (f_q >= LagF) begin
          bus.wr_en   = 1'b1;
          bus.wr_bank = ~src_q;
          bus.wr_addr = AW'(f_q - LagF);
          bus.wr_data = (cb_q && raster_border) ? 1'b0 : bus.filt_outcome;
          cnt_adv     = 1'b1;
          if (raster_last) begin
            if (pass_q == last_pass_q) begin
              result_d = ~src_q;
              state_d  = StDone;
            end else begin
              state_d = StNext;
            end
          end
        end
      end
      StNext: begin
        busy    = 1'b1;
        src_d   = ~src_q;
        pass_d  = pass_q + 1'b1;
        state_d = StClear;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ops_q       <= '0;
      last_pass_q <= '0;
      pass_q      <= '0;
      pad_q       <= 1'b0;
      cb_q        <= 1'b0;
      src_q       <= 1'b0;
      result_q    <= 1'b0;
      f_q         <= '0;
    end else begin
      state_q     <= state_d;
      ops_q       <= ops_d;
      last_pass_q <= last_pass_d;
      pass_q      <= pass_d;
      pad_q       <= pad_d;
      cb_q        <= cb_d;
      src_q       <= src_d;
      result_q    <= result_d;
      f_q         <= f_d;
    end
  end

  assign result_bank = result_q;

  // The raster counter and the feed counter must always name the same pixel on a write.
  logic [AW-1:0] raster_addr;
  assign raster_addr = AW'(32'(row) * WIDTH + 32'(col));

  raster_addr_a: assert property (@(posedge clock) disable iff (reset)
    bus.wr_en |-> (raster_addr == bus.wr_addr));

endmodule
